// File: rtl/bit_serializer_if.sv
// bit_serializer_if
//   Handshake and serial-stream bundle for bit_serializer.
//   Ports/signals:
//     in_data    - parallel word offered by the upstream source
//     in_valid   - in_data is valid
//     in_ready   - serializer can take a word this cycle
//     dout       - serial bit towards the sequence detector din
//     dout_valid - dout is valid (detector valid)
//     last_bit   - dout is the final bit of its word
//     busy       - shifter active or holding register occupied
//   Modports: master = upstream source view, slave = serializer view.
interface bit_serializer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             dout;
    logic             dout_valid;
    logic             last_bit;
    logic             busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, dout, dout_valid, last_bit, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, dout, dout_valid, last_bit, busy
    );
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial feeder for the serial sequence-detector FSMs.
//   Words arrive over a valid/ready handshake into a one-word holding
//   register and are shifted out one bit per clock. Once a word enters the
//   shifter all of its bits go out on consecutive cycles (the detector has
//   no backpressure); a word waiting in the holding register is loaded on
//   the last bit's edge so consecutive words stream without a gap.
//   Parameters:
//     WIDTH     - parallel word width, 2..32
//     MSB_FIRST - 1: bit WIDTH-1 sent first, 0: bit 0 sent first
//   Ports:
//     clk      - clock, all logic on posedge
//     rst      - synchronous active-high reset
//     bus      - bit_serializer_if.slave (handshake + serial stream)
//     word_cnt - (only with SER_WCNT_EN defined) saturating 16-bit count
//                of fully emitted words
//   Optional feature macro: SER_WCNT_EN
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    bit_serializer_if.slave   bus
`ifdef SER_WCNT_EN
    ,
    output logic [15:0]       word_cnt
`endif
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] hold;
    logic             hold_full;
    logic [CNT_W-1:0] cnt;

    logic at_last;
    logic shifter_free;
    logic load;
    logic accept;

    // The shifter can take a new word when idle or while its last bit is
    // on dout; loading on that edge is what keeps back-to-back words gapless.
    assign at_last      = (state == SHIFT) && (cnt == LAST_CNT);
    assign shifter_free = (state == IDLE) || at_last;
    assign load         = shifter_free && hold_full;

    // Ready only depends on the holding register and reset, so a held word
    // can never be overwritten.
    assign bus.in_ready = ~hold_full & ~rst;
    assign accept       = bus.in_valid & bus.in_ready;

    // Outputs are decoded purely from registered state.
    assign bus.dout_valid = (state == SHIFT);
    assign bus.dout       = MSB_FIRST ? sh[WIDTH-1] : sh[0];
    assign bus.last_bit   = at_last;
    assign bus.busy       = (state == SHIFT) | hold_full;

    // Main FSM: loads the shifter from hold, shifts one bit per clock and
    // manages the holding register. A same-edge accept refills hold while
    // its previous contents move into the shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            if (load) begin
                sh    <= hold;
                cnt   <= '0;
                state <= SHIFT;
            end else if (state == SHIFT) begin
                if (at_last) begin
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                    if (MSB_FIRST)
                        sh <= {sh[WIDTH-2:0], 1'b0};
                    else
                        sh <= {1'b0, sh[WIDTH-1:1]};
                end
            end

            if (accept) begin
                hold      <= bus.in_data;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end
    end

`ifdef SER_WCNT_EN
    // Counts words whose final bit has just been emitted; sticks at the
    // maximum rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (at_last && (word_cnt != 16'hFFFF)) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer
//   Directed self-checking bench for bit_serializer. Two instances share
//   clk/rst: u_msb (MSB_FIRST=1) and u_lsb (MSB_FIRST=0), each on its own
//   bit_serializer_if. Serial output is collected once per cycle into
//   shift registers and compared against hand-computed streams.
module tb_bit_serializer;
    logic clk;
    logic rst;

    bit_serializer_if #(.WIDTH(8)) bm ();
    bit_serializer_if #(.WIDTH(8)) bl ();

`ifdef SER_WCNT_EN
    logic [15:0] wcnt_m;
    logic [15:0] wcnt_l;
`endif

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk      (clk),
        .rst      (rst),
        .bus      (bm.slave)
`ifdef SER_WCNT_EN
        ,
        .word_cnt (wcnt_m)
`endif
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk      (clk),
        .rst      (rst),
        .bus      (bl.slave)
`ifdef SER_WCNT_EN
        ,
        .word_cnt (wcnt_l)
`endif
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] cap_m;
    int          cap_m_n;
    int          last_m_n;
    int          last_m_pos;
    int          falls_m;
    logic        prev_vm;
    logic [63:0] cap_l;
    int          cap_l_n;
    int          last_l_n;
    logic [4:0]  hist;
    logic        seq_seen;
    int          waits;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit sel, input logic [7:0] data, input logic valid);
        if (sel) begin
            bl.in_data  = data;
            bl.in_valid = valid;
        end else begin
            bm.in_data  = data;
            bm.in_valid = valid;
        end
    endtask

    task automatic clearCap();
        cap_m = '0; cap_m_n = 0; last_m_n = 0; last_m_pos = 0; falls_m = 0;
        cap_l = '0; cap_l_n = 0; last_l_n = 0;
        hist = '0; seq_seen = 1'b0;
    endtask

    // Advance one clock and sample just after the edge, collecting the
    // serial streams and a behavioural 01101 detector on the MSB stream.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bm.dout_valid) begin
            cap_m = {cap_m[62:0], bm.dout};
            cap_m_n++;
            if (bm.last_bit) begin
                last_m_n++;
                last_m_pos = cap_m_n;
            end
            hist = {hist[3:0], bm.dout};
            if (hist == 5'b01101) seq_seen = 1'b1;
        end else if (prev_vm) begin
            falls_m++;
        end
        prev_vm = bm.dout_valid;
        if (bl.dout_valid) begin
            cap_l = {cap_l[62:0], bl.dout};
            cap_l_n++;
            if (bl.last_bit) last_l_n++;
        end
    endtask

    // Offer one word on the MSB instance and wait (bounded) for acceptance.
    task automatic sendWord(input logic [7:0] data, output int n_wait);
        logic accepted;
        accepted = 1'b0;
        n_wait   = 0;
        applyStimulus(1'b0, data, 1'b1);
        for (int k = 0; k < 40; k++) begin
            if (bm.in_ready) begin
                tick();
                accepted = 1'b1;
                break;
            end
            n_wait++;
            tick();
        end
        checkOutput("word accepted", accepted, 1'b1);
    endtask

    task automatic waitIdle(input string tag);
        logic idle;
        idle = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (!bm.busy && !bm.dout_valid && !bl.busy && !bl.dout_valid) begin
                idle = 1'b1;
                break;
            end
            tick();
        end
        checkOutput(tag, idle, 1'b1);
    endtask

    initial begin
        prev_vm = 1'b0;
        clearCap();
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 8'h00, 1'b0);

        // Reset state
        tick();
        tick();
        checkOutput("rst dout_valid", bm.dout_valid, 1'b0);
        checkOutput("rst busy", bm.busy, 1'b0);
        checkOutput("rst last_bit", bm.last_bit, 1'b0);
        checkOutput("rst dout", bm.dout, 1'b0);
        checkOutput("rst in_ready", bm.in_ready, 1'b0);
        checkOutput("rst lsb in_ready", bl.in_ready, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("post-rst in_ready", bm.in_ready, 1'b1);
        $display("[TB] reset checks done");

        // Single word 0x0D, MSB first: 0,0,0,0,1,1,0,1
        clearCap();
        applyStimulus(1'b0, 8'h0D, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t1 accept dout_valid", bm.dout_valid, 1'b0);
        checkOutput("t1 accept busy", bm.busy, 1'b1);
        checkOutput("t1 hold full ready", bm.in_ready, 1'b0);
        tick();
        checkOutput("t1 first bit valid", bm.dout_valid, 1'b1);
        checkOutput("t1 first bit", bm.dout, 1'b0);
        waitIdle("t1 idle");
        checkOutput("t1 bit count", cap_m_n, 8);
        checkOutput("t1 stream", cap_m[7:0], 8'b0000_1101);
        checkOutput("t1 last_bit count", last_m_n, 1);
        checkOutput("t1 last_bit position", last_m_pos, 8);
        checkOutput("t1 detector 01101", seq_seen, 1'b1);

        // Back-to-back A5 then 3C with in_valid held high
        clearCap();
        applyStimulus(1'b0, 8'hA5, 1'b1);
        tick();
        checkOutput("t2 ready low hold full", bm.in_ready, 1'b0);
        applyStimulus(1'b0, 8'h3C, 1'b1);
        tick();
        checkOutput("t2 ready after load", bm.in_ready, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t2 ready low second held", bm.in_ready, 1'b0);
        checkOutput("t2 busy", bm.busy, 1'b1);
        waitIdle("t2 idle");
        checkOutput("t2 bit count", cap_m_n, 16);
        checkOutput("t2 stream", cap_m[15:0], 16'b1010_0101_0011_1100);
        checkOutput("t2 contiguous", falls_m, 1);
        checkOutput("t2 last_bit count", last_m_n, 2);

        // LSB-first instance, word 0x01 -> 1,0,0,0,0,0,0,0
        clearCap();
        applyStimulus(1'b1, 8'h01, 1'b1);
        tick();
        applyStimulus(1'b1, 8'h00, 1'b0);
        waitIdle("t3 idle");
        checkOutput("t3 bit count", cap_l_n, 8);
        checkOutput("t3 stream", cap_l[7:0], 8'b1000_0000);
        checkOutput("t3 last_bit count", last_l_n, 1);
        checkOutput("t3 msb untouched", cap_m_n, 0);

        // Three words with in_valid held high while busy
        clearCap();
        sendWord(8'h81, waits);
        checkOutput("t4 w0 no wait", waits, 0);
        sendWord(8'h42, waits);
        checkOutput("t4 w1 waited", waits > 0, 1'b1);
        sendWord(8'h24, waits);
        checkOutput("t4 w2 waited", waits > 0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        waitIdle("t4 idle");
        checkOutput("t4 bit count", cap_m_n, 24);
        checkOutput("t4 stream", cap_m[23:0], 24'h814224);
        checkOutput("t4 contiguous", falls_m, 1);
        checkOutput("t4 last_bit count", last_m_n, 3);
`ifdef SER_WCNT_EN
        checkOutput("t4 word_cnt msb", wcnt_m, 16'd6);
        checkOutput("t4 word_cnt lsb", wcnt_l, 16'd1);
`endif

        // Reset at the 4th bit of 0xFF with 0x55 held
        clearCap();
        applyStimulus(1'b0, 8'hFF, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h55, 1'b1);
        tick();
        checkOutput("t5 ready before accept", bm.in_ready, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("t5 second held", bm.in_ready, 1'b0);
        tick();
        tick();
        checkOutput("t5 bits before rst", cap_m_n, 4);
        rst = 1'b1;
        #1;
        checkOutput("t5 ready during rst", bm.in_ready, 1'b0);
        tick();
        checkOutput("t5 dout_valid after rst", bm.dout_valid, 1'b0);
        checkOutput("t5 busy after rst", bm.busy, 1'b0);
        checkOutput("t5 last_bit after rst", bm.last_bit, 1'b0);
        checkOutput("t5 dout after rst", bm.dout, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("t5 ready after rst", bm.in_ready, 1'b1);
        for (int k = 0; k < 12; k++) tick();
        checkOutput("t5 no stale bits", cap_m_n, 4);
        checkOutput("t5 stream prefix", cap_m[3:0], 4'hF);
        checkOutput("t5 still idle", bm.busy, 1'b0);
`ifdef SER_WCNT_EN
        checkOutput("t5 word_cnt cleared", wcnt_m, 16'd0);
`endif

        // Five words after reset
        clearCap();
        for (int w = 1; w <= 5; w++) sendWord(8'(w), waits);
        applyStimulus(1'b0, 8'h00, 1'b0);
        waitIdle("t6 idle");
        checkOutput("t6 bit count", cap_m_n, 40);
        checkOutput("t6 stream", cap_m[39:0], 40'h0102030405);
        checkOutput("t6 last_bit count", last_m_n, 5);
`ifdef SER_WCNT_EN
        checkOutput("t6 word_cnt", wcnt_m, 16'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
